input_port_ctrl: RTL and testbench
==================================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 16, flit width in bits.
REQ-002 SHALL have parameter COORD_BITS, default 2, width of each destination coordinate.
REQ-003 SHALL have parameters CUR_X, CUR_Y, default 0, this router's mesh coordinates.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port flit_i  input  FLIT_SIZE  head-of-queue flit from the upstream input buffer, combinationally valid when empty_i=0.
REQ-007 SHALL have port empty_i  input  1  upstream buffer empty flag.
REQ-008 SHALL have port read_o  output  1  pop strobe to the upstream buffer; the buffer advances on the same edge.
REQ-009 SHALL have port req_o  output  5  one-hot switch-allocator request: bit0 LOCAL, bit1 NORTH, bit2 SOUTH, bit3 EAST, bit4 WEST.
REQ-010 SHALL have port grant_i  input  1  per-cycle grant from the switch allocator for the current req_o.
REQ-011 SHALL have port flit_o  output  FLIT_SIZE  registered flit to the crossbar.
REQ-012 SHALL have port valid_o  output  1  flit_o valid qualifier.
REQ-013 SHALL have port credit_o  output  1  one-cycle credit pulse to the upstream router per popped flit.
REQ-014 SHALL have port error_o  output  1  one-cycle pulse when a protocol-violating flit is dropped.

Function
REQ-015 SHALL decode flit type from flit_i[FLIT_SIZE-1:FLIT_SIZE-2]: 2'b00 HEADTAIL, 2'b01 HEAD, 2'b10 BODY, 2'b11 TAIL.
REQ-016 SHALL take dest_x from the COORD_BITS bits below the type field and dest_y from the next COORD_BITS bits, in head/headtail flits only.
REQ-017 SHALL route XY, coordinates unsigned: dest_x>CUR_X EAST; dest_x<CUR_X WEST; else dest_y>CUR_Y NORTH; dest_y<CUR_Y SOUTH; else LOCAL.
REQ-018 SHALL implement FSM states IDLE, WAIT_SA, ACTIVE.
REQ-019 IDLE: empty_i=0 and type HEAD/HEADTAIL -> latch route into out_port register, go WAIT_SA; no pop that cycle.
REQ-020 IDLE: empty_i=0 and type BODY/TAIL -> read_o=1, credit_o=1, error_o=1 same cycle, flit dropped, stay IDLE.
REQ-021 WAIT_SA and ACTIVE: req_o SHALL equal out_port (one-hot); in IDLE req_o SHALL be 0.
REQ-022 WAIT_SA/ACTIVE: grant_i=1 and empty_i=0 -> read_o=1 and credit_o=1 combinationally that cycle; flit_o<=flit_i, valid_o<=1 at the edge (latency 1).
REQ-023 Popped flit HEADTAIL or TAIL -> next state IDLE; HEAD from WAIT_SA -> ACTIVE; BODY -> stay.
REQ-024 grant_i=1 with empty_i=1 SHALL not pop; valid_o<=0; state held (bubble).
REQ-025 A HEAD/HEADTAIL appearing while in ACTIVE SHALL be dropped with error_o pulse, read_o, credit_o; state held.
REQ-026 valid_o SHALL be 0 in any cycle following a cycle without a forwarding pop; flit_o holds last value.
REQ-027 read_o SHALL never be asserted while empty_i=1.
REQ-028 Back-to-back flits SHALL forward at one per cycle while grant_i and !empty_i hold.

Reset
REQ-029 rst=1 at a clock edge SHALL set state IDLE, out_port 0, flit_o 0, valid_o 0.
REQ-030 During rst=1, read_o, req_o, credit_o, error_o SHALL be 0.
REQ-031 Reset mid-packet SHALL abandon the packet; remaining buffered flits are then dropped as errors per REQ-020.

Structure
REQ-032 Flit-type codes, port one-hot codes, and field offsets SHALL live in shared package noc_params.
REQ-033 XY routing SHALL be a combinational sub-module route_xy (dest_x, dest_y -> one-hot port), reused by other input ports.

Verification
REQ-034 CUR=(1,1), HEADTAIL dest (3,1), grant_i=1 -> req_o=5'b01000 one cycle after arrival, valid_o one cycle after pop, state IDLE.
REQ-035 HEAD(dest 1,0)+BODY+BODY+TAIL, grant_i=1 always -> req_o=5'b00100, four consecutive valid_o, four credit_o pulses, return to IDLE.
REQ-036 Same packet, grant_i low two cycles mid-body -> no pop, valid_o=0 those cycles, req_o held, order preserved.
REQ-037 BODY flit first after reset -> read_o=credit_o=error_o=1 for one cycle, req_o=0, valid_o stays 0.
REQ-038 HEAD dest (1,1) at CUR=(1,1) -> req_o=5'b00001 (LOCAL); rst asserted after head popped -> next edge state IDLE, all outputs 0.
REQ-039 Empty buffer mid-packet with grant_i=1 -> read_o=0, valid_o=0, ACTIVE held until next flit arrives.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC constants: flit type codes, output-port one-hot codes, header field layout
// and the input-port controller state encoding.
package noc_params;

  localparam int TYPE_BITS = 2;
  localparam int NUM_PORTS = 5;

  typedef enum logic [1:0] {
    FT_HEADTAIL = 2'b00,
    FT_HEAD     = 2'b01,
    FT_BODY     = 2'b10,
    FT_TAIL     = 2'b11
  } flit_type_t;

  localparam logic [NUM_PORTS-1:0] PORT_LOCAL = 5'b00001;
  localparam logic [NUM_PORTS-1:0] PORT_NORTH = 5'b00010;
  localparam logic [NUM_PORTS-1:0] PORT_SOUTH = 5'b00100;
  localparam logic [NUM_PORTS-1:0] PORT_EAST  = 5'b01000;
  localparam logic [NUM_PORTS-1:0] PORT_WEST  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_SA = 2'd1,
    ACTIVE  = 2'd2
  } ipc_state_t;

  // dest_x sits directly below the type field, dest_y directly below dest_x
  function automatic int dest_x_msb(int flit_size);
    return flit_size - TYPE_BITS - 1;
  endfunction

  function automatic int dest_y_msb(int flit_size, int coord_bits);
    return flit_size - TYPE_BITS - coord_bits - 1;
  endfunction

  function automatic logic is_head(flit_type_t t);
    return (t == FT_HEAD) || (t == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/input_port_ctrl_if.sv
// Input-port bundle: upstream buffer side, switch-allocator side and crossbar side.
interface input_port_ctrl_if #(
  parameter int FLIT_SIZE = 16
) ();

  logic [FLIT_SIZE-1:0]            flit_i;
  logic                            empty_i;
  logic                            read_o;
  logic [noc_params::NUM_PORTS-1:0] req_o;
  logic                            grant_i;
  logic [FLIT_SIZE-1:0]            flit_o;
  logic                            valid_o;
  logic                            credit_o;
  logic                            error_o;

  modport master (
    input  flit_i, empty_i, grant_i,
    output read_o, req_o, flit_o, valid_o, credit_o, error_o
  );

  modport slave (
    output flit_i, empty_i, grant_i,
    input  read_o, req_o, flit_o, valid_o, credit_o, error_o
  );

endinterface

// File: rtl/route_xy.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
module route_xy
  import noc_params::*;
#(
  parameter int COORD_BITS = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic [COORD_BITS-1:0] dest_x,
  input  logic [COORD_BITS-1:0] dest_y,
  output logic [NUM_PORTS-1:0]  port
);

  localparam logic [COORD_BITS-1:0] CX = COORD_BITS'(CUR_X);
  localparam logic [COORD_BITS-1:0] CY = COORD_BITS'(CUR_Y);

  always_comb begin
    port = PORT_LOCAL;
    if (dest_x > CX)      port = PORT_EAST;
    else if (dest_x < CX) port = PORT_WEST;
    else if (dest_y > CY) port = PORT_NORTH;
    else if (dest_y < CY) port = PORT_SOUTH;
  end

endmodule

// File: rtl/input_port_ctrl.sv
// Wormhole input-port controller: routes a packet's head, requests the switch, and forwards
// flits to the crossbar one per granted cycle, dropping protocol-violating flits.
module input_port_ctrl
  import noc_params::*;
#(
  parameter int FLIT_SIZE  = 16,
  parameter int COORD_BITS = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input logic               clk,
  input logic               rst,
  input_port_ctrl_if.master bus
);

  localparam int X_MSB = dest_x_msb(FLIT_SIZE);
  localparam int Y_MSB = dest_y_msb(FLIT_SIZE, COORD_BITS);

  ipc_state_t           state, next_state;
  logic [NUM_PORTS-1:0] out_port;
  logic [NUM_PORTS-1:0] route;
  flit_type_t           ftype;
  logic                 head_flit;
  logic                 fwd_pop;
  logic                 drop;

  assign ftype     = flit_type_t'(bus.flit_i[FLIT_SIZE-1 -: TYPE_BITS]);
  assign head_flit = is_head(ftype);

  route_xy #(
    .COORD_BITS(COORD_BITS),
    .CUR_X     (CUR_X),
    .CUR_Y     (CUR_Y)
  ) u_route (
    .dest_x(bus.flit_i[X_MSB -: COORD_BITS]),
    .dest_y(bus.flit_i[Y_MSB -: COORD_BITS]),
    .port  (route)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!bus.empty_i && head_flit) next_state = WAIT_SA;
      WAIT_SA, ACTIVE: begin
        if (fwd_pop) begin
          case (ftype)
            FT_HEADTAIL, FT_TAIL: next_state = IDLE;
            FT_HEAD:              next_state = ACTIVE;
            default:              next_state = state;
          endcase
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A stray head inside an open packet is dropped whether or not the switch granted.
  always_comb begin
    fwd_pop   = 1'b0;
    drop      = 1'b0;
    bus.req_o = '0;
    if (!rst) begin
      case (state)
        IDLE: drop = !bus.empty_i && !head_flit;
        WAIT_SA: begin
          bus.req_o = out_port;
          fwd_pop   = bus.grant_i && !bus.empty_i;
        end
        ACTIVE: begin
          bus.req_o = out_port;
          if (!bus.empty_i) begin
            if (head_flit) drop = 1'b1;
            else           fwd_pop = bus.grant_i;
          end
        end
        default: ;
      endcase
    end
    bus.read_o   = fwd_pop || drop;
    bus.credit_o = fwd_pop || drop;
    bus.error_o  = drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port    <= '0;
      bus.flit_o  <= '0;
      bus.valid_o <= 1'b0;
    end else begin
      if (state == IDLE && !bus.empty_i && head_flit) out_port <= route;
      bus.valid_o <= fwd_pop;
      if (fwd_pop) bus.flit_o <= bus.flit_i;
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Random packet streams through a modelled upstream buffer; a packet-level reference model
// fills a scoreboard that a negedge monitor drains against the DUT outputs.
module tb_input_port_ctrl;

  localparam int FS = 16;
  localparam int CB = 2;
  localparam int CX = 1;
  localparam int CY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  input_port_ctrl_if #(.FLIT_SIZE(FS)) bus ();

  input_port_ctrl #(
    .FLIT_SIZE (FS),
    .COORD_BITS(CB),
    .CUR_X     (CX),
    .CUR_Y     (CY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] flit;
    logic [4:0]  route;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fifo[$];
  logic [15:0] pending[$];
  int          total = 0;
  int          bad = 0;
  bit          in_pkt = 1'b0;
  logic [4:0]  cur_route = '0;
  bit          prev_fwd = 1'b0;
  bit          last_rd = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got event expected none at %0t", name, $time);
  endtask

  function automatic logic [4:0] route_ref(int dx, int dy);
    if (dx > CX) return 5'b01000;
    if (dx < CX) return 5'b10000;
    if (dy > CY) return 5'b00010;
    if (dy < CY) return 5'b00100;
    return 5'b00001;
  endfunction

  function automatic logic [15:0] mk(int t, int dx, int dy);
    logic [1:0] tt, xx, yy;
    logic [9:0] pay;
    tt  = t[1:0];
    xx  = dx[1:0];
    yy  = dy[1:0];
    pay = 10'($urandom);
    return {tt, xx, yy, pay};
  endfunction

  // Packet-level view: outside a packet only heads are legal, inside only body/tail.
  task automatic model_push(input logic [15:0] f);
    exp_t e;
    int   t;
    t = int'(f[15:14]);
    e.flit = f;
    e.is_err = 1'b0;
    e.route = '0;
    if (!in_pkt) begin
      if (t == 0 || t == 1) begin
        cur_route = route_ref(int'(f[13:12]), int'(f[11:10]));
        e.route = cur_route;
        if (t == 1) in_pkt = 1'b1;
      end else begin
        e.is_err = 1'b1;
      end
    end else begin
      if (t == 0 || t == 1) begin
        e.is_err = 1'b1;
      end else begin
        e.route = cur_route;
        if (t == 3) in_pkt = 1'b0;
      end
    end
    exp_q.push_back(e);
    pending.push_back(f);
  endtask

  task automatic drive();
    bus.empty_i = (fifo.size() == 0);
    bus.flit_i  = (fifo.size() > 0) ? fifo[0] : 16'h0;
  endtask

  task automatic tick(input int push_pct, input int grant_pct);
    bit rd;
    @(negedge clk);
    rd = bus.read_o;
    @(posedge clk);
    #1;
    last_rd = rd;
    if (rd && fifo.size() > 0) void'(fifo.pop_front());
    if (pending.size() > 0 && $urandom_range(99) < push_pct) fifo.push_back(pending.pop_front());
    bus.grant_i = ($urandom_range(99) < grant_pct);
    drive();
  endtask

  task automatic apply_stimulus(input int push_pct, input int grant_pct, input int budget);
    int n = 0;
    while ((pending.size() > 0 || fifo.size() > 0 || exp_q.size() > 0) && n < budget) begin
      tick(push_pct, grant_pct);
      n++;
    end
    if (n >= budget) note_fail("drain_timeout");
  endtask

  task automatic gen_packet();
    int len;
    if ($urandom_range(9) == 0) model_push(mk($urandom_range(3), $urandom_range(3), $urandom_range(3)));
    len = $urandom_range(1, 4);
    if (len == 1) begin
      model_push(mk(0, $urandom_range(3), $urandom_range(3)));
    end else begin
      model_push(mk(1, $urandom_range(3), $urandom_range(3)));
      for (int i = 0; i < len - 2; i++) model_push(mk(2, $urandom_range(3), $urandom_range(3)));
      model_push(mk(3, $urandom_range(3), $urandom_range(3)));
    end
  endtask

  // Outputs are sampled mid-cycle; forwarded data is judged the cycle after its pop.
  always @(negedge clk) begin
    check_output("valid_follows_pop", bus.valid_o, prev_fwd);
    if (bus.valid_o) begin
      if (exp_q.size() == 0 || exp_q[0].is_err) note_fail("unexpected_valid");
      else begin
        check_output("flit_o", bus.flit_o, exp_q[0].flit);
        void'(exp_q.pop_front());
      end
    end
    if (rst) begin
      check_output("rst_read_o", bus.read_o, 0);
      check_output("rst_req_o", bus.req_o, 0);
      check_output("rst_credit_o", bus.credit_o, 0);
      check_output("rst_error_o", bus.error_o, 0);
      prev_fwd = 1'b0;
    end else begin
      check_output("credit_eq_read", bus.credit_o, bus.read_o);
      check_output("read_needs_data", bus.read_o && bus.empty_i, 0);
      if (bus.read_o && !bus.error_o) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) note_fail("unexpected_forward");
        else begin
          check_output("req_o_route", bus.req_o, exp_q[0].route);
          check_output("popped_flit", bus.flit_i, exp_q[0].flit);
        end
      end
      if (bus.error_o) begin
        check_output("error_has_read", bus.read_o, 1);
        if (exp_q.size() == 0 || !exp_q[0].is_err) note_fail("unexpected_error");
        else begin
          check_output("dropped_flit", bus.flit_i, exp_q[0].flit);
          void'(exp_q.pop_front());
        end
      end
      prev_fwd = bus.read_o && !bus.error_o;
    end
  end

  initial begin
    bus.grant_i = 1'b0;
    drive();
    rst = 1'b1;
    repeat (3) tick(0, 0);
    check_output("reset_flit_o", bus.flit_o, 0);
    check_output("reset_valid_o", bus.valid_o, 0);
    rst = 1'b0;

    // Stray body first, then the east-bound single-flit packet and a south-bound 4-flit packet
    model_push(mk(2, 0, 0));
    model_push(mk(0, 3, 1));
    model_push(mk(1, 1, 0));
    model_push(mk(2, 0, 0));
    model_push(mk(2, 0, 0));
    model_push(mk(3, 0, 0));
    apply_stimulus(100, 100, 200);

    repeat (200) gen_packet();
    apply_stimulus(60, 70, 20000);

    // Reset right after a local-bound head leaves; its body and tail become orphans
    model_push(mk(1, 1, 1));
    last_rd = 1'b0;
    for (int n = 0; n < 20 && !last_rd; n++) tick(100, 100);
    if (!last_rd) note_fail("head_pop_timeout");
    rst = 1'b1;
    in_pkt = 1'b0;
    tick(0, 0);
    check_output("midrst_flit_o", bus.flit_o, 0);
    check_output("midrst_valid_o", bus.valid_o, 0);
    tick(0, 0);
    rst = 1'b0;
    model_push(mk(2, 0, 0));
    model_push(mk(3, 0, 0));
    apply_stimulus(100, 100, 200);

    repeat (2) tick(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
